// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the PWM DAC output stage.
//   PWM_WIDTH    - sample / counter width in bits
//   PWM_PERIOD   - PWM period in clock cycles (counter runs 0..PWM_PERIOD-1)
//   pwm_sample_t - unsigned duty / sample type
package pwm_pkg;

    localparam int PWM_WIDTH  = 8;
    localparam int PWM_PERIOD = 255;

    typedef logic [PWM_WIDTH-1:0] pwm_sample_t;

endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running period counter for the PWM DAC.
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high
//   en    in  count enable; a disabled edge clears the counter
//   count out current count, 0..PERIOD-1
//   wrap  out high while count == PERIOD-1 (last cycle of the period)
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Disabling parks the counter at 0 so re-enable always starts a fresh
    // period; the wrap goes straight from LAST to 0 without an idle cycle.
    always_comb begin
        count_d = count_q;
        if (!en || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = (count_q == LAST);

endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: converts an unsigned sample into a registered single-bit PWM
// output. PWM_o is high for exactly `duty` edges out of every PERIOD.
//   clk          in  system clock, rising edge
//   rst          in  synchronous reset, active-high (priority over en)
//   en           in  PWM enable; a disabled edge forces PWM_o low and
//                    restarts the period on re-enable
//   mixed_sample in  unsigned duty value (0 = 0%, PERIOD = 100%)
//   PWM_o        out registered PWM output
// Build option PWM_SAMPLE_LATCH_EN: latch the duty at period boundaries
// (and on the first enabled edge) for glitch-free duty updates. Without it
// the compare uses the live mixed_sample every cycle.
module pwm_dac
    import pwm_pkg::*;
#(
    parameter int WIDTH  = PWM_WIDTH,
    parameter int PERIOD = PWM_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] mixed_sample,
    output logic             PWM_o
);

    logic [WIDTH-1:0] count;
    logic             wrap;
    logic [WIDTH-1:0] duty_cmp;
    logic             pwm_q;
    logic             pwm_d;

    pwm_counter #(
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (count),
        .wrap  (wrap)
    );

`ifdef PWM_SAMPLE_LATCH_EN
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             running_q;
    logic             running_d;
    logic             load;

    // Load on the first enabled edge after reset/disable and on the last
    // edge of each period. The loading edge compares against the incoming
    // sample so first-edge latency matches the unlatched build.
    always_comb begin
        load      = en && (!running_q || wrap);
        duty_d    = duty_q;
        running_d = en;
        duty_cmp  = duty_q;
        if (load) begin
            duty_d   = mixed_sample;
            duty_cmp = mixed_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q    <= '0;
            running_q <= 1'b0;
        end else begin
            duty_q    <= duty_d;
            running_q <= running_d;
        end
    end
`else
    logic unused_wrap;

    assign unused_wrap = wrap;

    always_comb begin
        duty_cmp = mixed_sample;
    end
`endif

    // Output reflects the count value from before the edge.
    always_comb begin
        pwm_d = 1'b0;
        if (en) begin
            pwm_d = (count < duty_cmp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign PWM_o = pwm_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: scoreboard bench for pwm_dac. The stimulus process drives one
// edge per step and queues the expected PWM_o; the monitor pops and compares
// one entry after every rising edge.
module tb_pwm_dac;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] mixed_sample = 8'd0;
    logic       PWM_o;

    int    total = 0;
    int    bad = 0;
    int    hi_cnt = 0;
    bit    exp_q[$];
    string tag_q[$];
    int    k_q[$];
    bit    mon_exp;
    string mon_tag;
    int    mon_k;

    pwm_dac dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mixed_sample (mixed_sample),
        .PWM_o        (PWM_o)
    );

    always #5 clk = ~clk;

    // Edge k after enable sees count (k-1) mod 255; high while below duty.
    function automatic bit exp_bit(input int k, input int duty);
        return ((k - 1) % 255) < duty;
    endfunction

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_k   = k_q.pop_front();
            total++;
            if (PWM_o !== mon_exp) begin
                bad++;
                $display("FAIL %s edge %0d: PWM_o=%b expected %b", mon_tag, mon_k, PWM_o, mon_exp);
            end
            if (PWM_o === 1'b1) hi_cnt++;
        end
    end

    task automatic step(input bit r, input bit e, input logic [7:0] s,
                        input bit exp, input string tag, input int k);
        @(negedge clk);
        rst = r;
        en = e;
        mixed_sample = s;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        k_q.push_back(k);
    endtask

    task automatic run(input logic [7:0] s, input int n, input string tag);
        for (int k = 1; k <= n; k++) step(1'b0, 1'b1, s, exp_bit(k, s), tag, k);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 1; k <= n; k++) step(1'b0, 1'b0, mixed_sample, 1'b0, tag, k);
    endtask

    // Bounded wait for the monitor to consume everything queued so far.
    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        // Reset, first idle then with en asserted: rst must win.
        for (int k = 1; k <= 2; k++) step(1'b1, 1'b0, 8'd0, 1'b0, "rst_idle", k);
        for (int k = 1; k <= 2; k++) step(1'b1, 1'b1, 8'd255, 1'b0, "rst_en", k);

        // Half duty: 127 highs per 255-edge window, high again at edge 256.
        drain();
        hi_cnt = 0;
        for (int k = 1; k <= 255; k++) step(1'b0, 1'b1, 8'd127, exp_bit(k, 127), "half", k);
        drain();
        total++;
        if (hi_cnt != 127) begin
            bad++;
            $display("FAIL half_window: highs=%0d expected 127", hi_cnt);
        end
        step(1'b0, 1'b1, 8'd127, 1'b1, "half", 256);
        idle(1, "half_off");

        run(8'd0, 600, "zero");
        idle(1, "zero_off");

        run(8'd255, 600, "full");
        idle(1, "full_off");

        // Disable mid-period, then re-enable: period restarts from count 0,
        // so the lows begin at edge 201 rather than 151.
        run(8'd200, 50, "dis_pre");
        idle(3, "dis");
        run(8'd200, 210, "reen");
        idle(1, "reen_off");

        // Sample change at edge 100.
        for (int k = 1; k <= 510; k++) begin
            logic [7:0] s;
            bit         e;
            s = (k < 100) ? 8'd50 : 8'd200;
`ifdef PWM_SAMPLE_LATCH_EN
            e = exp_bit(k, (k <= 255) ? 50 : 200);
`else
            e = exp_bit(k, int'(s));
`endif
            step(1'b0, 1'b1, s, e, "latch", k);
        end
        idle(1, "latch_off");

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
